// File: rtl/reg_share_arbiter_pkg.sv
// Shared types and elaboration-time helpers for the shared-register write arbiter.
package reg_share_arbiter_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_LOCKED = 1'b1
  } arb_state_e;

  function automatic int clog2(input int value);
    int bits = 0;
    while ((1 << bits) < value) bits++;
    return bits;
  endfunction

  function automatic int idx_bits(input int n);
    return (n > 1) ? clog2(n) : 1;
  endfunction

  // Index arithmetic modulo n; n need not be a power of two.
  function automatic int wrap_add(input int idx, input int k, input int n);
    int s = idx + k;
    while (s >= n) s -= n;
    return s;
  endfunction

endpackage

// File: rtl/reg_share_arbiter_register.sv
// Plain loadable data register used as the shared datapath.
module Register #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic [WIDTH-1:0] in,
  input  logic             load,
  output logic [WIDTH-1:0] out
);

  always_ff @(posedge clk) begin
    if (load) out <= in;
  end

endmodule

// File: rtl/reg_share_arbiter_rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr, wrapping.
module rr_pick
  import reg_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] idx_o,
  output logic             valid_o
);

  logic [IDX_W-1:0] cand;

  // Walk the rotation backwards so the nearest requester to ptr wins last.
  always_comb begin
    gnt_o   = '0;
    idx_o   = '0;
    valid_o = 1'b0;
    cand    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      cand = IDX_W'(wrap_add(int'(ptr_i), k, N_REQ));
      if (req_i[cand]) begin
        gnt_o       = '0;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
        valid_o     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Round-robin write arbiter with optional watchdog-limited lock, sharing one Register.
module reg_share_arbiter
  import reg_share_arbiter_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int WIDTH    = 16,
  parameter int LOCK_MAX = 16,
  localparam int IDX_W   = idx_bits(N_REQ),
  localparam int CNT_W   = clog2(LOCK_MAX) + 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] wdata,
  input  logic [N_REQ-1:0]       lock,
  output logic [N_REQ-1:0]       gnt,
  output logic [WIDTH-1:0]       out,
  output logic                   locked,
  output logic [IDX_W-1:0]       owner,
  output logic                   lock_err
);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d, owner_q, owner_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             lock_err_q, lock_err_d;

  logic [N_REQ-1:0] pick_gnt;
  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             reg_load;
  logic [WIDTH-1:0] reg_in;
  logic [WIDTH-1:0] wdata_a [N_REQ];

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign wdata_a[i] = wdata[i*WIDTH +: WIDTH];
  end

  rr_pick #(.N_REQ(N_REQ), .IDX_W(IDX_W)) u_pick (
    .req_i   (req),
    .ptr_i   (ptr_q),
    .gnt_o   (pick_gnt),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    cnt_d      = cnt_q;
    lock_err_d = 1'b0;
    gnt        = '0;
    reg_load   = 1'b0;
    reg_in     = wdata_a[owner_q];
    if (!rst_n) begin
      // Clear the shared register while reset is held.
      reg_load = 1'b1;
      reg_in   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (pick_valid) begin
            gnt      = pick_gnt;
            reg_load = 1'b1;
            reg_in   = wdata_a[pick_idx];
            owner_d  = pick_idx;
            ptr_d    = IDX_W'(wrap_add(int'(pick_idx), 1, N_REQ));
            if (lock[pick_idx]) begin
              state_d = ST_LOCKED;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        ST_LOCKED: begin
          gnt[owner_q] = req[owner_q];
          reg_load     = req[owner_q];
          if (!lock[owner_q]) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else if (cnt_q == CNT_W'(LOCK_MAX - 1)) begin
            state_d    = ST_IDLE;
            cnt_d      = '0;
            lock_err_d = 1'b1;
            ptr_d      = IDX_W'(wrap_add(int'(owner_q), 1, N_REQ));
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      cnt_q      <= '0;
      lock_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      cnt_q      <= cnt_d;
      lock_err_q <= lock_err_d;
    end
  end

  assign locked   = (state_q == ST_LOCKED);
  assign owner    = owner_q;
  assign lock_err = lock_err_q;

  Register #(.WIDTH(WIDTH)) u_reg (
    .clk  (clk),
    .in   (reg_in),
    .load (reg_load),
    .out  (out)
  );

endmodule
